// File: rtl/eth_rx_mac_filter_if.sv
// Header + byte-stream bus used on both sides of the RX MAC filter.
// The master drives the header, the payload and their valids. The slave drives the readys.
interface eth_rx_mac_filter_if;
   localparam int unsigned MAC_W  = 48;
   localparam int unsigned TYPE_W = 16;
   localparam int unsigned DATA_W = 8;

   logic              hdr_valid;
   logic              hdr_ready;
   logic [MAC_W-1:0]  dest_mac;
   logic [MAC_W-1:0]  src_mac;
   logic [TYPE_W-1:0] eth_type;
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic              tuser;

   modport master (
      output hdr_valid, dest_mac, src_mac, eth_type,
      output tdata, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, dest_mac, src_mac, eth_type,
      input  tdata, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/eth_rx_mac_filter.sv
// Ethernet RX destination-MAC filter. It forwards frames for this station
// (unicast, broadcast, optional multicast, or promiscuous), drains all others, and counts both outcomes.
module eth_rx_mac_filter #(
   parameter bit          ALLOW_BROADCAST = 1'b1,
   parameter bit          ALLOW_MULTICAST = 1'b0,
   parameter int unsigned COUNT_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [47:0]            local_mac,
   input  logic                   promisc,
   input  logic                   cnt_clr,
   eth_rx_mac_filter_if.slave     s_eth,
   eth_rx_mac_filter_if.master    m_eth,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] pass_count,
   output logic [COUNT_WIDTH-1:0] drop_count
);
   localparam int unsigned MAC_W     = 48;
   localparam int unsigned TYPE_W    = 16;
   localparam int unsigned GROUP_BIT = 40;
   localparam logic [MAC_W-1:0] BCAST_MAC = '1;

   typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              match;
   logic              pass_inc;
   logic              drop_inc;
   logic              hdr_done;
   logic              hdr_valid_q;
   logic [MAC_W-1:0]  dest_q;
   logic [MAC_W-1:0]  src_q;
   logic [TYPE_W-1:0] type_q;

   // Decided only at header acceptance, so later changes to local_mac and promisc cannot affect a frame in flight.
   always_comb begin
      match = promisc
            | (s_eth.dest_mac == local_mac)
            | (ALLOW_BROADCAST & (s_eth.dest_mac == BCAST_MAC))
            | (ALLOW_MULTICAST & s_eth.dest_mac[GROUP_BIT]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      pass_inc        = 1'b0;
      drop_inc        = 1'b0;
      hdr_done        = 1'b0;
      s_eth.hdr_ready = 1'b0;
      s_eth.tready    = 1'b0;
      m_eth.tdata     = '0;
      m_eth.tvalid    = 1'b0;
      m_eth.tlast     = 1'b0;
      m_eth.tuser     = 1'b0;
      unique case (state)
         IDLE: begin
            s_eth.hdr_ready = 1'b1;
            if (s_eth.hdr_valid) begin
               if (match) begin
                  pass_inc  = 1'b1;
                  state_nxt = HDR;
               end else begin
                  drop_inc  = 1'b1;
                  state_nxt = DROP;
               end
            end
         end
         HDR: begin
            if (m_eth.hdr_ready) begin
               hdr_done  = 1'b1;
               state_nxt = FWD;
            end
         end
         FWD: begin
            m_eth.tdata  = s_eth.tdata;
            m_eth.tvalid = s_eth.tvalid;
            m_eth.tlast  = s_eth.tlast;
            m_eth.tuser  = s_eth.tuser;
            s_eth.tready = m_eth.tready;
            if (s_eth.tvalid && m_eth.tready && s_eth.tlast) state_nxt = IDLE;
         end
         DROP: begin
            s_eth.tready = 1'b1;
            if (s_eth.tvalid && s_eth.tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The output header is captured at acceptance and held until downstream takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_valid_q <= 1'b0;
         dest_q      <= '0;
         src_q       <= '0;
         type_q      <= '0;
      end else if (pass_inc) begin
         hdr_valid_q <= 1'b1;
         dest_q      <= s_eth.dest_mac;
         src_q       <= s_eth.src_mac;
         type_q      <= s_eth.eth_type;
      end else if (hdr_done) begin
         hdr_valid_q <= 1'b0;
      end
   end

   assign m_eth.hdr_valid = hdr_valid_q;
   assign m_eth.dest_mac  = dest_q;
   assign m_eth.src_mac   = src_q;
   assign m_eth.eth_type  = type_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= 1'b0;
      else      busy <= (state_nxt != IDLE);
   end

   // Saturating counters. A clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_count <= '0;
         drop_count <= '0;
      end else if (cnt_clr) begin
         pass_count <= '0;
         drop_count <= '0;
      end else begin
         if (pass_inc && (pass_count != '1)) pass_count <= pass_count + COUNT_WIDTH'(1);
         if (drop_inc && (drop_count != '1)) drop_count <= drop_count + COUNT_WIDTH'(1);
      end
   end
endmodule
